// File: rtl/beat_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : beat_timing_gen_if
// Description : Request/beat bundle between the hardwired controller and the
//               beat (W-state) generator.
//               master : drives QD, DP, SHORT, LONG, STOP; observes the beats
//               slave  : the beat generator itself
//               Signals: QD start level, DP single-step, SHORT/LONG cycle
//               length requests, STOP halt request, W1/W2/W3 beats,
//               RUN busy flag, CYCLES completed machine-cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
interface beat_timing_gen_if #(
  parameter int CYC_W = 16
);
  logic             QD;
  logic             DP;
  logic             SHORT;
  logic             LONG;
  logic             STOP;
  logic             W1;
  logic             W2;
  logic             W3;
  logic             RUN;
  logic [CYC_W-1:0] CYCLES;

  modport master (
    output QD, DP, SHORT, LONG, STOP,
    input  W1, W2, W3, RUN, CYCLES
  );

  modport slave (
    input  QD, DP, SHORT, LONG, STOP,
    output W1, W2, W3, RUN, CYCLES
  );
endinterface
`default_nettype wire

// File: rtl/beat_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : beat_timing_gen
// Description : Beat generator for the hardwired control unit. Issues W1/W2/W3
//               machine-cycle beats, handles start (QD edge), continuous run,
//               single-step (DP) and controller halt (STOP), and counts
//               completed machine cycles.
//               Ports:
//                 T3  - beat clock, everything advances on its rising edge
//                 CLR - asynchronous active-high reset
//                 bus - beat_timing_gen_if.slave (requests in, beats out)
// Revision    : 1.0 - initial release
// ============================================================================
module beat_timing_gen #(
  parameter int CYC_W = 16
) (
  input  wire logic         T3,
  input  wire logic         CLR,
  beat_timing_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  localparam logic [CYC_W-1:0] c_one = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic             r_qd_q;
  logic             r_stop_seen;
  logic [CYC_W-1:0] r_cycles;
  logic             r_w1;
  logic             r_w2;
  logic             r_w3;
  logic             r_run;
  logic             w_start;
  logic             w_eoc;
  logic             w_halt;

  assign w_start = bus.QD & ~r_qd_q;
  // A STOP seen earlier in the cycle is remembered so it still halts at the end.
  assign w_halt  = r_stop_seen | bus.STOP | bus.DP;

  always_comb begin
    w_next = r_state;
    w_eoc  = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_next = B1;
      B1: begin
        if (bus.SHORT) w_eoc  = 1'b1;
        else           w_next = B2;
      end
      B2: begin
        if (bus.LONG) w_next = B3;
        else          w_eoc  = 1'b1;
      end
      B3:      w_eoc = 1'b1;
      default: w_next = IDLE;
    endcase
    // End of cycle chains straight into the next B1 unless a halt is pending.
    if (w_eoc) w_next = w_halt ? IDLE : B1;
  end

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      // qd_q starts high so a QD held through reset is not seen as a start.
      r_qd_q      <= 1'b1;
      r_stop_seen <= 1'b0;
      r_cycles    <= '0;
      r_w1        <= 1'b0;
      r_w2        <= 1'b0;
      r_w3        <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_qd_q <= bus.QD;
      if (w_eoc) begin
        r_cycles    <= r_cycles + c_one;
        r_stop_seen <= 1'b0;
      end else if ((r_state != IDLE) && bus.STOP) begin
        r_stop_seen <= 1'b1;
      end
      // Beats are registered decodes of the next state, so outputs never
      // carry a combinational path from the inputs.
      r_w1  <= (w_next == B1);
      r_w2  <= (w_next == B2);
      r_w3  <= (w_next == B3);
      r_run <= (w_next != IDLE);
    end
  end

  assign bus.W1     = r_w1;
  assign bus.W2     = r_w2;
  assign bus.W3     = r_w3;
  assign bus.RUN    = r_run;
  assign bus.CYCLES = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_beat_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_timing_gen
// Description : Self-checking bench for beat_timing_gen. Directed scenarios and
//               randomized requests are compared against a behavioural model
//               that tracks "running", the beat number within the cycle and a
//               pending-halt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_timing_gen;

  localparam int CW = 4;

  logic T3;
  logic CLR;
  int   n_checks;
  int   n_errors;

  // behavioural model
  bit m_run;
  int m_beat;
  bit m_stop;
  bit m_qd;
  int m_cyc;

  beat_timing_gen_if #(.CYC_W(CW)) bus ();

  beat_timing_gen #(.CYC_W(CW)) dut (
    .T3  (T3),
    .CLR (CLR),
    .bus (bus)
  );

  initial T3 = 1'b0;
  always #5 T3 = ~T3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_beat = 0;
    m_stop = 1'b0;
    m_qd   = 1'b1;
    m_cyc  = 0;
  endtask

  task automatic model_edge();
    bit st;
    bit done;
    st   = bus.QD && !m_qd;
    m_qd = bus.QD;
    if (!m_run) begin
      if (st) begin
        m_run  = 1'b1;
        m_beat = 1;
      end
    end else begin
      done = (m_beat == 1 && bus.SHORT) || (m_beat == 2 && !bus.LONG) || (m_beat == 3);
      if (done) begin
        m_cyc = (m_cyc + 1) % (1 << CW);
        if (m_stop || bus.STOP || bus.DP) m_run = 1'b0;
        else m_beat = 1;
        m_stop = 1'b0;
      end else begin
        if (bus.STOP) m_stop = 1'b1;
        m_beat = m_beat + 1;
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [3:0] exp_v;
    exp_v = {m_run && m_beat == 1, m_run && m_beat == 2, m_run && m_beat == 3, m_run};
    check({tag, ".beats"}, {28'd0, bus.W1, bus.W2, bus.W3, bus.RUN}, {28'd0, exp_v});
    check({tag, ".cycles"}, {{(32-CW){1'b0}}, bus.CYCLES}, m_cyc);
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check.
  task automatic step(input string tag, input logic qd, input logic dp,
                      input logic sh, input logic lg, input logic st);
    bus.QD    = qd;
    bus.DP    = dp;
    bus.SHORT = sh;
    bus.LONG  = lg;
    bus.STOP  = st;
    @(posedge T3);
    model_edge();
    @(negedge T3);
    compare(tag);
  endtask

  // Asynchronous clear between edges; outputs must drop before any clock edge.
  task automatic do_clr(input string tag);
    #2 CLR = 1'b1;
    #1;
    check({tag, ".clr_beats"}, {28'd0, bus.W1, bus.W2, bus.W3, bus.RUN}, 32'd0);
    check({tag, ".clr_cycles"}, {{(32-CW){1'b0}}, bus.CYCLES}, 32'd0);
    model_reset();
    @(negedge T3);
    #2 CLR = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    CLR       = 1'b1;
    bus.QD    = 1'b1;
    bus.DP    = 1'b0;
    bus.SHORT = 1'b0;
    bus.LONG  = 1'b0;
    bus.STOP  = 1'b0;
    model_reset();
    #3;
    compare("reset");
    @(negedge T3);
    #2 CLR = 1'b0;

    // QD held high through reset must not start.
    step("qd_held", 1, 0, 0, 0, 0);
    step("qd_held2", 1, 0, 0, 0, 0);

    // SHORT cycles: W1 held, one cycle counted per edge.
    step("short_lo", 0, 0, 1, 0, 0);
    step("short_go", 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("short_run", 1, 0, 1, 0, 0);
    check("short_cnt5", {{(32-CW){1'b0}}, bus.CYCLES}, 32'd5);
    step("short_halt", 0, 0, 1, 0, 1);

    // Normal free run W1,W2 alternating.
    do_clr("c1");
    step("free_lo", 0, 0, 0, 0, 0);
    step("free_go", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("free_run", 0, 0, 0, 0, 0);
    check("free_cnt2", {{(32-CW){1'b0}}, bus.CYCLES}, 32'd2);

    // LONG in B2 gives W3.
    step("long_b2", 0, 0, 0, 1, 0);
    step("long_b3", 0, 0, 0, 1, 0);
    step("long_b1", 0, 0, 0, 1, 0);

    // One-edge STOP pulse during W1 still lets W2 run, then halts.
    step("stop_b2", 0, 0, 0, 0, 1);
    step("stop_end", 0, 0, 0, 0, 0);
    check("stop_idle", {31'd0, bus.RUN}, 32'd0);
    step("stop_idle2", 0, 0, 0, 0, 0);
    step("resume", 1, 0, 0, 0, 0);
    check("resume_w1", {31'd0, bus.W1}, 32'd1);

    // Single-step: one W1,W2 pair per QD pulse; QD edge during run ignored.
    do_clr("c2");
    step("dp_lo", 0, 1, 0, 0, 0);
    step("dp_go1", 1, 1, 0, 0, 0);
    step("dp_w2", 0, 1, 0, 0, 0);
    step("dp_end1", 1, 1, 0, 0, 0);
    step("dp_idle", 0, 1, 0, 0, 0);
    step("dp_go2", 1, 1, 0, 0, 0);
    step("dp_w2b", 0, 1, 0, 0, 0);
    step("dp_qd_mid", 1, 1, 0, 0, 0);
    step("dp_idle2", 1, 1, 0, 0, 0);
    check("dp_cnt2", {{(32-CW){1'b0}}, bus.CYCLES}, 32'd2);

    // CLR mid-W2 with QD held high.
    do_clr("c3");
    step("clr_lo", 0, 0, 0, 0, 0);
    step("clr_go", 1, 0, 0, 0, 0);
    step("clr_w2", 1, 0, 0, 0, 0);
    do_clr("clr_mid");
    step("clr_qdhi", 1, 0, 0, 0, 0);
    step("clr_qdhi2", 1, 0, 0, 0, 0);
    step("clr_qdlo", 0, 0, 0, 0, 0);
    step("clr_restart", 1, 0, 0, 0, 0);

    // Randomized requests; counter width small enough to exercise wrap.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_clr("rnd_clr");
      end
      step("rnd",
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
